// File: rtl/perf_event_counters.sv
// Performance event counters: one cycle counter plus NUM_EVENTS event counters.
// Counting is gated by an IDLE/RUN/FROZEN state machine, and counters are read through a registered select port.
module perf_event_counters #(
  parameter int NUM_EVENTS = 5,
  parameter int CNT_WIDTH  = 32,
  parameter int SEL_WIDTH  = 3,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clr,
  input  logic                  halt,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  rd_req,
  input  logic [SEL_WIDTH-1:0]  rd_sel,
  output logic                  rd_valid,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic [NUM_EVENTS:0]   ovf,
  output logic                  running,
  output logic                  frozen
);

  localparam int NUM_CNT = NUM_EVENTS + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 running_q, running_d;
  logic                 frozen_q, frozen_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CNT];
  logic [NUM_EVENTS:0]  ovf_q, ovf_d;
  logic [NUM_EVENTS:0]  inc_s;
  logic                 rd_valid_q, rd_valid_d;
  logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [CNT_WIDTH-1:0] sel_val_s;

  // Next-state logic; in IDLE a same-cycle stop is ignored, and clr only leaves FROZEN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (halt || stop) state_d = ST_FROZEN;
        else              state_d = ST_RUN;
      end
      ST_FROZEN: begin
        if (clr) state_d = ST_IDLE;
        else     state_d = ST_FROZEN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track state_q exactly.
  always_comb begin
    running_d = (state_d == ST_RUN);
    frozen_d  = (state_d == ST_FROZEN);
  end

  // Counter update; clr wins over a same-cycle increment, and ovf is sticky until clr.
  always_comb begin
    inc_s[0]            = (state_q == ST_RUN);
    inc_s[NUM_EVENTS:1] = events & {NUM_EVENTS{state_q == ST_RUN}};
    ovf_d               = ovf_q;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (inc_s[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
          if (SATURATE) cnt_d[i] = cnt_q[i];
          else          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Read mux is an AND-OR over pre-update values, so out-of-range selects give 0.
  always_comb begin
    sel_val_s = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      sel_val_s = sel_val_s | (cnt_q[k] & {CNT_WIDTH{rd_sel == SEL_WIDTH'(k)}});
    end
    rd_valid_d = rd_req;
    if (rd_req) rd_data_d = sel_val_s;
    else        rd_data_d = rd_data_q;
  end

  // State, counters, flags and read port registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      running_q  <= 1'b0;
      frozen_q   <= 1'b0;
      ovf_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      running_q  <= running_d;
      frozen_q   <= frozen_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign ovf      = ovf_q;
  assign running  = running_q;
  assign frozen   = frozen_q;

endmodule

// File: tb/tb_perf_event_counters.sv
// Directed bench for perf_event_counters: a 32-bit wrapping instance plus 8-bit wrap and saturate instances share one stimulus.
module tb_perf_event_counters;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, stop = 1'b0, clr = 1'b0, halt = 1'b0, rd_req = 1'b0;
  logic [4:0] events = 5'b00000;
  logic [2:0] rd_sel = 3'd0;

  logic        rd_valid, running, frozen;
  logic [31:0] rd_data;
  logic [5:0]  ovf;
  logic        w_rd_valid, w_running, w_frozen;
  logic [7:0]  w_rd_data;
  logic [5:0]  w_ovf;
  logic        s_rd_valid, s_running, s_frozen;
  logic [7:0]  s_rd_data;
  logic [5:0]  s_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  perf_event_counters #(.NUM_EVENTS(5), .CNT_WIDTH(32), .SEL_WIDTH(3), .SATURATE(1'b0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .halt(halt),
    .events(events), .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rd_valid),
    .rd_data(rd_data), .ovf(ovf), .running(running), .frozen(frozen));

  perf_event_counters #(.NUM_EVENTS(5), .CNT_WIDTH(8), .SEL_WIDTH(3), .SATURATE(1'b0)) u_dut_w8 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .halt(halt),
    .events(events), .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(w_rd_valid),
    .rd_data(w_rd_data), .ovf(w_ovf), .running(w_running), .frozen(w_frozen));

  perf_event_counters #(.NUM_EVENTS(5), .CNT_WIDTH(8), .SEL_WIDTH(3), .SATURATE(1'b1)) u_dut_s8 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .halt(halt),
    .events(events), .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(s_rd_valid),
    .rd_data(s_rd_data), .ovf(s_ovf), .running(s_running), .frozen(s_frozen));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] sel);
    rd_req = 1'b1;
    rd_sel = sel;
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    // reset values
    #12;
    check("rst_running", 64'(running), 64'd0);
    check("rst_frozen", 64'(frozen), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_w8_running", 64'(w_running), 64'd0);
    rst = 1'b1;
    tick();

    // 10 run cycles with events[0], then halt counted in its own cycle
    start = 1'b1; tick(); start = 1'b0;
    check("run_after_start", 64'(running), 64'd1);
    events = 5'b00001;
    repeat (10) tick();
    halt = 1'b1; tick(); halt = 1'b0;
    events = 5'b00000;
    check("halt_frozen", 64'(frozen), 64'd1);
    check("halt_running", 64'(running), 64'd0);
    rd(3'd0); check("t1_valid", 64'(rd_valid), 64'd1); check("t1_cycle", 64'(rd_data), 64'd11);
    rd(3'd1); check("t1_cnt1", 64'(rd_data), 64'd11);
    rd(3'd2); check("t1_cnt2", 64'(rd_data), 64'd0);

    // FROZEN ignores start and events; clr returns to IDLE
    start = 1'b1; tick(); start = 1'b0;
    check("frozen_ignores_start", 64'(frozen), 64'd1);
    events = 5'b11111;
    repeat (5) tick();
    events = 5'b00000;
    rd(3'd0); check("frozen_cycle", 64'(rd_data), 64'd11);
    rd(3'd1); check("frozen_cnt1", 64'(rd_data), 64'd11);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_frozen", 64'(frozen), 64'd0);
    check("clr_idle_running", 64'(running), 64'd0);
    rd(3'd0); check("clr_cycle", 64'(rd_data), 64'd0);
    check("clr_ovf", 64'(ovf), 64'd0);

    // start with stop in IDLE goes to RUN
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("start_stop_run", 64'(running), 64'd1);

    // clr beats a same-cycle increment and counting continues
    events = 5'b00010;
    repeat (7) tick();
    events = 5'b00000;
    rd(3'd2); check("cnt2_pre_clr", 64'(rd_data), 64'd7);
    clr = 1'b1; events = 5'b00010; tick(); clr = 1'b0; events = 5'b00000;
    rd(3'd2); check("cnt2_clr_prio", 64'(rd_data), 64'd0);
    check("clr_keeps_run", 64'(running), 64'd1);
    events = 5'b00010; tick(); events = 5'b00000;
    rd(3'd2); check("cnt2_after_clr", 64'(rd_data), 64'd1);

    // back-to-back reads are snapshots before each edge's update
    clr = 1'b1; tick(); clr = 1'b0;
    events = 5'b00001;
    repeat (4) tick();
    rd_req = 1'b1; rd_sel = 3'd0; tick();
    check("b2b_valid0", 64'(rd_valid), 64'd1); check("b2b_cycle", 64'(rd_data), 64'd4);
    rd_sel = 3'd1; tick();
    check("b2b_valid1", 64'(rd_valid), 64'd1); check("b2b_cnt1", 64'(rd_data), 64'd5);
    rd_sel = 3'd7; tick();
    check("b2b_valid2", 64'(rd_valid), 64'd1); check("b2b_sel7", 64'(rd_data), 64'd0);
    rd_sel = 3'd1; events = 5'b00000; tick();
    check("b2b_cnt1_b", 64'(rd_data), 64'd7);
    rd_req = 1'b0; tick();
    check("idle_valid", 64'(rd_valid), 64'd0); check("hold_data", 64'(rd_data), 64'd7);

    // 8-bit wrap and saturate overflow after 257 events
    clr = 1'b1; tick(); clr = 1'b0;
    events = 5'b00001;
    repeat (255) tick();
    check("w8_ovf_pre", 64'(w_ovf), 64'd0);
    check("s8_ovf_pre", 64'(s_ovf), 64'd0);
    repeat (2) tick();
    events = 5'b00000;
    halt = 1'b1; tick(); halt = 1'b0;
    check("w8_frozen", 64'(w_frozen), 64'd1);
    check("s8_frozen", 64'(s_frozen), 64'd1);
    rd(3'd1);
    check("w8_cnt1_wrap", 64'(w_rd_data), 64'd1);
    check("s8_valid", 64'(s_rd_valid), 64'd1);
    check("s8_cnt1_sat", 64'(s_rd_data), 64'd255);
    check("w32_cnt1", 64'(rd_data), 64'd257);
    rd(3'd0);
    check("w8_cycle_wrap", 64'(w_rd_data), 64'd2);
    check("s8_cycle_sat", 64'(s_rd_data), 64'd255);
    check("w32_cycle", 64'(rd_data), 64'd258);
    check("w8_ovf", 64'(w_ovf), 64'd3);
    check("s8_ovf", 64'(s_ovf), 64'd3);
    check("w32_no_ovf", 64'(ovf), 64'd0);

    // clr with halt in RUN: counters zeroed and state FROZEN
    clr = 1'b1; tick(); clr = 1'b0;
    check("w8_ovf_cleared", 64'(w_ovf), 64'd0);
    start = 1'b1; tick(); start = 1'b0;
    events = 5'b00001;
    repeat (3) tick();
    clr = 1'b1; halt = 1'b1; tick(); clr = 1'b0; halt = 1'b0;
    events = 5'b00000;
    check("clr_halt_frozen", 64'(frozen), 64'd1);
    rd(3'd1); check("clr_halt_cnt1", 64'(rd_data), 64'd0);
    rd(3'd0); check("clr_halt_cycle", 64'(rd_data), 64'd0);

    // asynchronous reset mid-RUN with a read in flight
    clr = 1'b1; tick(); clr = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    events = 5'b00001;
    repeat (3) tick();
    rd_req = 1'b1; rd_sel = 3'd0; tick();
    check("pre_rst_valid", 64'(rd_valid), 64'd1);
    check("pre_rst_data", 64'(rd_data), 64'd3);
    #2 rst = 1'b0;
    #1;
    check("async_rd_valid", 64'(rd_valid), 64'd0);
    check("async_rd_data", 64'(rd_data), 64'd0);
    check("async_running", 64'(running), 64'd0);
    check("async_s8_running", 64'(s_running), 64'd0);
    rd_req = 1'b0; events = 5'b00000;
    @(posedge clk);
    #2 rst = 1'b1;
    tick();
    rd(3'd0);
    check("post_rst_valid", 64'(rd_valid), 64'd1);
    check("post_rst_cycle", 64'(rd_data), 64'd0);
    rd(3'd1); check("post_rst_cnt1", 64'(rd_data), 64'd0);
    check("post_rst_idle", 64'(running), 64'd0);
    check("post_rst_frozen", 64'(frozen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
